// File: rtl/integ_decim_3rd_pkg.sv
// Shared filter package: default widths and the modular adder used by the
// CIC integrator and comb stages.
package integ_decim_3rd_pkg;

  localparam int unsigned FILT_WIDTH = 51;
  localparam int unsigned FILT_RW    = 16;

  // Widest datapath the shared adder supports; narrower users truncate.
  localparam int unsigned ADD_MAX_W  = 64;

  // Two's-complement add that wraps modulo 2^ADD_MAX_W; callers keep the
  // low bits, which gives wrap modulo 2^WIDTH for any WIDTH <= ADD_MAX_W.
  function automatic logic [ADD_MAX_W-1:0] mod_add(
    input logic [ADD_MAX_W-1:0] a,
    input logic [ADD_MAX_W-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/integ_stage.sv
// Single integrator stage: combinational wrap-around accumulate, acc + x.
module integ_stage
  import integ_decim_3rd_pkg::*;
#(
  parameter int unsigned WIDTH = FILT_WIDTH
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] sum_c
);

  // Widen, add through the shared helper, keep the low WIDTH bits.
  always_comb begin
    sum_c = WIDTH'(mod_add(ADD_MAX_W'(acc_i), ADD_MAX_W'(x_i)));
  end

endmodule

// File: rtl/integ_decim_3rd.sv
// Third-order CIC integrator section with programmable decimation.
// Three chained integrators run at the input rate; every R-th accepted
// sample the last accumulator is registered onto yout with a one-cycle pulse.
module integ_decim_3rd
  import integ_decim_3rd_pkg::*;
#(
  parameter int unsigned WIDTH = FILT_WIDTH,
  parameter int unsigned RW    = FILT_RW
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    xin_valid,
  input  logic signed [WIDTH-1:0] xin,
  input  logic        [RW-1:0]    ratio,
  output logic signed [WIDTH-1:0] yout,
  output logic                    yout_valid
);

  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] a2_q, a2_d;
  logic [WIDTH-1:0] a3_q, a3_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    ratio_q, ratio_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] yout_q, yout_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] s1_c, s2_c, s3_c;
  logic [RW-1:0]    r_frame_c;
  logic [RW-1:0]    r_eff_c;
  logic             frame_end_c;

  // Chained integrators: each stage adds the freshly updated previous stage.
  integ_stage #(.WIDTH(WIDTH)) u_stage1 (.acc_i(a1_q), .x_i(xin),  .sum_c(s1_c));
  integ_stage #(.WIDTH(WIDTH)) u_stage2 (.acc_i(a2_q), .x_i(s1_c), .sum_c(s2_c));
  integ_stage #(.WIDTH(WIDTH)) u_stage3 (.acc_i(a3_q), .x_i(s2_c), .sum_c(s3_c));

  // Ratio in force for the current frame; until the first post-reset latch
  // the port value is used directly so reset never needs an async data load.
  always_comb begin
    r_frame_c   = pend_q ? ratio : ratio_q;
    r_eff_c     = (r_frame_c == '0) ? RW'(1) : r_frame_c;
    frame_end_c = (cnt_q == (r_eff_c - RW'(1)));
  end

  // Next-state: accumulate accepted samples, count phase, emit on wrap.
  always_comb begin
    a1_d    = a1_q;
    a2_d    = a2_q;
    a3_d    = a3_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    pend_d  = pend_q;
    yout_d  = yout_q;
    valid_d = 1'b0;
    if (clk_enable) begin
      if (pend_q) begin
        ratio_d = ratio;
        pend_d  = 1'b0;
      end
      if (xin_valid) begin
        a1_d = s1_c;
        a2_d = s2_c;
        a3_d = s3_c;
        if (frame_end_c) begin
          cnt_d   = '0;
          ratio_d = ratio;
          yout_d  = s3_c;
          valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + RW'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1_q    <= '0;
      a2_q    <= '0;
      a3_q    <= '0;
      cnt_q   <= '0;
      ratio_q <= '0;
      pend_q  <= 1'b1;
      yout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      a3_q    <= a3_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      pend_q  <= pend_d;
      yout_q  <= yout_d;
      valid_q <= valid_d;
    end
  end

  assign yout       = yout_q;
  assign yout_valid = valid_q;

endmodule

// File: tb/tb_integ_decim_3rd.sv
// Bench for integ_decim_3rd: directed cases plus randomized streams checked
// against a closed-form third-order integrator model.
module tb_integ_decim_3rd;

  localparam int unsigned W  = 51;
  localparam int unsigned RW = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                clk_enable;
  logic                xin_valid;
  logic signed [W-1:0] xin;
  logic [RW-1:0]       ratio;
  logic signed [W-1:0] yout;
  logic                yout_valid;

  int checks   = 0;
  int failures = 0;

  // Model state: all accepted samples since reset, frame phase and ratio.
  logic [63:0]  acc_xs[$];
  int           cnt_m;
  int           r_cur;
  bit           pend;
  logic [W-1:0] exp_y;
  logic         exp_v;

  integ_decim_3rd #(.WIDTH(W), .RW(RW)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .xin_valid  (xin_valid),
    .xin        (xin),
    .ratio      (ratio),
    .yout       (yout),
    .yout_valid (yout_valid)
  );

  always #5 clk = ~clk;

  // Triple running sum in closed form: y[n] = sum_k C(n-k+2,2) * x[k] mod 2^W.
  function automatic logic [W-1:0] model_a3();
    logic [63:0] s;
    int n;
    s = '0;
    n = acc_xs.size() - 1;
    for (int k = 0; k <= n; k++) begin
      s = s + 64'((n - k + 1) * (n - k + 2) / 2) * acc_xs[k];
    end
    return W'(s);
  endfunction

  function automatic int eff(input logic [RW-1:0] r);
    return (r == '0) ? 1 : int'(r);
  endfunction

  function automatic logic [W-1:0] rand_x();
    return W'({$urandom, $urandom});
  endfunction

  // Apply one cycle of inputs, then advance the model to the post-edge view.
  task automatic drive(input bit ce, input bit v, input logic [W-1:0] x);
    clk_enable = ce;
    xin_valid  = v;
    xin        = x;
    @(posedge clk);
    #1;
    exp_v = 1'b0;
    if (ce) begin
      if (pend) begin
        r_cur = eff(ratio);
        pend  = 1'b0;
      end
      if (v) begin
        acc_xs.push_back(64'(x));
        cnt_m++;
        if (cnt_m == r_cur) begin
          exp_y = model_a3();
          exp_v = 1'b1;
          cnt_m = 0;
          r_cur = eff(ratio);
        end
      end
    end
  endtask

  task automatic do_reset();
    clk_enable = 1'b0;
    xin_valid  = 1'b0;
    xin        = '0;
    reset      = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    acc_xs.delete();
    cnt_m = 0;
    r_cur = 1;
    pend  = 1'b1;
    exp_y = '0;
    exp_v = 1'b0;
  endtask

  task automatic test_reset();
    ratio      = RW'(3);
    clk_enable = 1'b1;
    xin_valid  = 1'b1;
    xin        = W'(5);
    reset      = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (yout !== W'(0)) begin
      failures++;
      $display("FAIL reset_yout got=%h want=0", yout);
    end
    checks++;
    if (yout_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b want=0", yout_valid);
    end
    do_reset();
    checks++;
    if (yout !== W'(0) || yout_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got=%h/%b want=0/0", yout, yout_valid);
    end
  endtask

  task automatic test_step();
    int want[5] = '{1, 4, 10, 20, 35};
    ratio = RW'(1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, W'(1));
      checks++;
      if (yout !== W'(want[i]) || yout_valid !== 1'b1) begin
        failures++;
        $display("FAIL step[%0d] got=%0d/%b want=%0d/1", i, yout, yout_valid, want[i]);
      end
    end
  endtask

  task automatic test_impulse();
    int want[5] = '{1, 3, 6, 10, 15};
    ratio = RW'(1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, (i == 0) ? W'(1) : W'(0));
      checks++;
      if (yout !== W'(want[i]) || yout_valid !== 1'b1) begin
        failures++;
        $display("FAIL impulse[%0d] got=%0d/%b want=%0d/1", i, yout, yout_valid, want[i]);
      end
    end
  endtask

  task automatic test_decim();
    int want[3]  = '{4, 20, 56};
    int want0[3] = '{1, 4, 10};
    int held;
    ratio = RW'(2);
    do_reset();
    held = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, W'(1));
      if (i % 2 == 1) held = want[i / 2];
      checks++;
      if (yout !== W'(held) || yout_valid !== bit'(i % 2)) begin
        failures++;
        $display("FAIL decim2[%0d] got=%0d/%b want=%0d/%0d", i, yout, yout_valid, held, i % 2);
      end
    end
    ratio = RW'(0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, W'(1));
      checks++;
      if (yout !== W'(want0[i]) || yout_valid !== 1'b1) begin
        failures++;
        $display("FAIL ratio0[%0d] got=%0d/%b want=%0d/1", i, yout, yout_valid, want0[i]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [W-1:0] big;
    logic [W-1:0] m4;
    big   = (W'(1) << 50) - W'(1);
    m4    = W'(0) - W'(4);
    ratio = RW'(1);
    do_reset();
    drive(1'b1, 1'b1, big);
    checks++;
    if (yout !== big || yout_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_first got=%h/%b want=%h/1", yout, yout_valid, big);
    end
    drive(1'b1, 1'b1, big);
    checks++;
    if (yout !== m4 || yout_valid !== 1'b1) begin
      failures++;
      $display("FAIL wrap_second got=%h/%b want=%h/1", yout, yout_valid, m4);
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] xs[$];
    logic [W-1:0] q_ref[$];
    logic [W-1:0] q_gap[$];
    bit ce;
    ratio = RW'($urandom_range(1, 5));
    for (int i = 0; i < 40; i++) xs.push_back(rand_x());
    do_reset();
    foreach (xs[i]) begin
      drive(1'b1, 1'b1, xs[i]);
      if (yout_valid) q_ref.push_back(yout);
      checks++;
      if (yout !== exp_y || yout_valid !== exp_v) begin
        failures++;
        $display("FAIL gapfree[%0d] got=%h/%b want=%h/%b", i, yout, yout_valid, exp_y, exp_v);
      end
    end
    do_reset();
    foreach (xs[i]) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        ce = bit'($urandom_range(0, 1));
        drive(ce, ce ? 1'b0 : bit'($urandom_range(0, 1)), rand_x());
        if (yout_valid) q_gap.push_back(yout);
        checks++;
        if (yout_valid !== 1'b0 || yout !== exp_y) begin
          failures++;
          $display("FAIL gap_idle[%0d] ce=%0d got=%h/%b want=%h/0", i, ce, yout, yout_valid, exp_y);
        end
      end
      drive(1'b1, 1'b1, xs[i]);
      if (yout_valid) q_gap.push_back(yout);
      checks++;
      if (yout !== exp_y || yout_valid !== exp_v) begin
        failures++;
        $display("FAIL gap_sample[%0d] got=%h/%b want=%h/%b", i, yout, yout_valid, exp_y, exp_v);
      end
    end
    checks++;
    if (q_gap.size() != q_ref.size()) begin
      failures++;
      $display("FAIL gap_count got=%0d want=%0d", q_gap.size(), q_ref.size());
    end else begin
      foreach (q_ref[i]) begin
        checks++;
        if (q_gap[i] !== q_ref[i]) begin
          failures++;
          $display("FAIL gap_seq[%0d] got=%h want=%h", i, q_gap[i], q_ref[i]);
        end
      end
    end
  endtask

  task automatic test_ratio_change();
    ratio = RW'(3);
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) ratio = RW'($urandom_range(0, 4));
      drive(1'b1, bit'($urandom_range(0, 3) != 0), rand_x());
      checks++;
      if (yout !== exp_y || yout_valid !== exp_v) begin
        failures++;
        $display("FAIL ratio_chg[%0d] got=%h/%b want=%h/%b", i, yout, yout_valid, exp_y, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    ratio = RW'(4);
    do_reset();
    drive(1'b1, 1'b1, W'(1));
    drive(1'b1, 1'b1, W'(1));
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, W'(1));
      checks++;
      if (yout !== ((i == 3) ? W'(20) : W'(0)) || yout_valid !== (i == 3)) begin
        failures++;
        $display("FAIL reset_mid[%0d] got=%0d/%b want=%0d/%0d", i, yout, yout_valid,
                 (i == 3) ? 20 : 0, (i == 3));
      end
    end
  endtask

  task automatic test_roundtrip();
    logic [W-1:0] xs[$];
    logic [W-1:0] ys[$];
    logic [W-1:0] y0, y1, y2, y3, d;
    ratio = RW'(1);
    do_reset();
    for (int i = 0; i < 30; i++) begin
      xs.push_back(rand_x());
      if ($urandom_range(0, 3) == 0) drive(1'b1, 1'b0, rand_x());
      drive(1'b1, 1'b1, xs[i]);
      if (yout_valid) ys.push_back(yout);
    end
    checks++;
    if (ys.size() != xs.size()) begin
      failures++;
      $display("FAIL rt_count got=%0d want=%0d", ys.size(), xs.size());
    end else begin
      foreach (xs[n]) begin
        y0 = ys[n];
        y1 = (n >= 1) ? ys[n-1] : W'(0);
        y2 = (n >= 2) ? ys[n-2] : W'(0);
        y3 = (n >= 3) ? ys[n-3] : W'(0);
        d  = y0 - W'(3) * y1 + W'(3) * y2 - y3;
        checks++;
        if (d !== xs[n]) begin
          failures++;
          $display("FAIL roundtrip[%0d] got=%h want=%h", n, d, xs[n]);
        end
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    clk_enable = 1'b0;
    xin_valid  = 1'b0;
    xin        = '0;
    ratio      = RW'(1);
    test_reset();
    test_step();
    test_impulse();
    test_decim();
    test_wrap();
    test_gaps();
    test_ratio_change();
    test_reset_mid();
    test_roundtrip();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
